// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: data-stall detection, forwarding select, mult/div busy tracking.
// Latency: stall/enable/forward outputs are combinational (zero cycles); md_busy is registered.
// Backpressure: stall freezes PC and F/D and flushes D/E; optional stall counter via HAZARD_STALL_CNT_EN.
module hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rs_D,
    input  logic [4:0]  Rt_D,
    input  logic [1:0]  Tuse_Rs_D,
    input  logic [1:0]  Tuse_Rt_D,
    input  logic [4:0]  A3_E,
    input  logic [4:0]  A3_M,
    input  logic [4:0]  A3_W,
    input  logic [1:0]  Tnew_E,
    input  logic [1:0]  Tnew_M,
    input  logic        md_start,
    input  logic        md_type,
    input  logic        md_use_D,
    output logic        stall,
    output logic        en_PC,
    output logic        en_FD,
    output logic        flush_DE,
    output logic [1:0]  fwd_Rs_D,
    output logic [1:0]  fwd_Rt_D,
    output logic        md_busy
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    // Busy-cycle counts for the two mult/div flavours.
    localparam logic [3:0] MULT_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES  = 4'd10;

    logic [3:0] r_md_cnt;
    logic       r_md_busy;
    logic [3:0] w_md_cnt_next;

    logic w_hit_e_rs, w_hit_m_rs, w_hit_w_rs;
    logic w_hit_e_rt, w_hit_m_rt, w_hit_w_rt;
    logic w_stall_rs, w_stall_rt;
    logic w_stall_data, w_stall_md, w_stall;

    // Priority select: youngest ready producer wins, register file otherwise.
    function automatic logic [1:0] f_fwd_sel(input logic hit_e, input logic hit_m,
                                             input logic hit_w, input logic [1:0] tnew_e,
                                             input logic [1:0] tnew_m);
        logic [1:0] sel;
        sel = 2'd0;
        if (hit_e && (tnew_e == 2'd0))      sel = 2'd1;
        else if (hit_m && (tnew_m == 2'd0)) sel = 2'd2;
        else if (hit_w)                     sel = 2'd3;
        return sel;
    endfunction

    // Register-match, stall and forwarding decode; $zero never matches anything.
    always_comb begin
        w_hit_e_rs = (Rs_D != 5'd0) && (A3_E == Rs_D);
        w_hit_m_rs = (Rs_D != 5'd0) && (A3_M == Rs_D);
        w_hit_w_rs = (Rs_D != 5'd0) && (A3_W == Rs_D);
        w_hit_e_rt = (Rt_D != 5'd0) && (A3_E == Rt_D);
        w_hit_m_rt = (Rt_D != 5'd0) && (A3_M == Rt_D);
        w_hit_w_rt = (Rt_D != 5'd0) && (A3_W == Rt_D);

        // Tuse of 3 marks an unused operand, which can never wait on a producer.
        w_stall_rs = (Tuse_Rs_D != 2'd3) &&
                     ((w_hit_e_rs && (Tnew_E > Tuse_Rs_D)) ||
                      (w_hit_m_rs && (Tnew_M > Tuse_Rs_D)));
        w_stall_rt = (Tuse_Rt_D != 2'd3) &&
                     ((w_hit_e_rt && (Tnew_E > Tuse_Rt_D)) ||
                      (w_hit_m_rt && (Tnew_M > Tuse_Rt_D)));

        w_stall_data = w_stall_rs || w_stall_rt;
        // md_start is included so the issuing cycle itself also holds a dependent instruction.
        w_stall_md   = md_use_D && (r_md_busy || md_start);
        w_stall      = w_stall_data || w_stall_md;

        stall    = w_stall;
        en_PC    = ~w_stall;
        en_FD    = ~w_stall;
        flush_DE = w_stall;

        fwd_Rs_D = f_fwd_sel(w_hit_e_rs, w_hit_m_rs, w_hit_w_rs, Tnew_E, Tnew_M);
        fwd_Rt_D = f_fwd_sel(w_hit_e_rt, w_hit_m_rt, w_hit_w_rt, Tnew_E, Tnew_M);
    end

    // Next mult/div count: a new start always reloads, otherwise count down to zero and hold.
    always_comb begin
        w_md_cnt_next = 4'd0;
        if (md_start)
            w_md_cnt_next = md_type ? DIV_CYCLES : MULT_CYCLES;
        else if (r_md_cnt != 4'd0)
            w_md_cnt_next = r_md_cnt - 4'd1;
    end

    // Counter and busy flag; busy is registered from the next count so it tracks cnt != 0 exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_md_cnt  <= 4'd0;
            r_md_busy <= 1'b0;
        end else begin
            r_md_cnt  <= w_md_cnt_next;
            r_md_busy <= (w_md_cnt_next != 4'd0);
        end
    end

    assign md_busy = r_md_busy;

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Free-running stall-cycle counter, wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (reset)
            r_stall_cnt <= 32'd0;
        else if (w_stall)
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes expected outputs, a monitor pops and compares.
// Inputs are driven 1 time unit after posedge; outputs are sampled on negedge.
// Optional stall counter is checked only when HAZARD_STALL_CNT_EN is defined.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  Rs_D = '0, Rt_D = '0, A3_E = '0, A3_M = '0, A3_W = '0;
    logic [1:0]  Tuse_Rs_D = '0, Tuse_Rt_D = '0, Tnew_E = '0, Tnew_M = '0;
    logic        md_start = 1'b0, md_type = 1'b0, md_use_D = 1'b0;
    logic        stall, en_PC, en_FD, flush_DE, md_busy;
    logic [1:0]  fwd_Rs_D, fwd_Rt_D;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    hazard_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .Rs_D      (Rs_D),
        .Rt_D      (Rt_D),
        .Tuse_Rs_D (Tuse_Rs_D),
        .Tuse_Rt_D (Tuse_Rt_D),
        .A3_E      (A3_E),
        .A3_M      (A3_M),
        .A3_W      (A3_W),
        .Tnew_E    (Tnew_E),
        .Tnew_M    (Tnew_M),
        .md_start  (md_start),
        .md_type   (md_type),
        .md_use_D  (md_use_D),
        .stall     (stall),
        .en_PC     (en_PC),
        .en_FD     (en_FD),
        .flush_DE  (flush_DE),
        .fwd_Rs_D  (fwd_Rs_D),
        .fwd_Rt_D  (fwd_Rt_D),
        .md_busy   (md_busy)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        stall;
        logic [1:0]  fwd_rs;
        logic [1:0]  fwd_rt;
        logic        busy;
        logic        chk_cnt;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic        exp_chk_cnt = 1'b0;
    logic [31:0] exp_cnt     = '0;

    // Apply one cycle of inputs and record the hand-computed response.
    task automatic vec(input string name, input logic rst,
                       input logic [4:0] rs, input logic [1:0] trs,
                       input logic [4:0] rt, input logic [1:0] trt,
                       input logic [4:0] ae, input logic [1:0] te,
                       input logic [4:0] am, input logic [1:0] tm,
                       input logic [4:0] aw,
                       input logic ms, input logic mt, input logic mu,
                       input logic es, input logic [1:0] ers, input logic [1:0] ert,
                       input logic eb);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; Rs_D = rs; Tuse_Rs_D = trs; Rt_D = rt; Tuse_Rt_D = trt;
        A3_E = ae; Tnew_E = te; A3_M = am; Tnew_M = tm; A3_W = aw;
        md_start = ms; md_type = mt; md_use_D = mu;
        e.name = name; e.stall = es; e.fwd_rs = ers; e.fwd_rt = ert; e.busy = eb;
        e.chk_cnt = exp_chk_cnt; e.cnt = exp_cnt;
        sb_q.push_back(e);
    endtask

    // Monitor: every cycle with a pending expectation, compare the sampled outputs.
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if (stall !== e.stall || en_PC !== ~e.stall || en_FD !== ~e.stall ||
                flush_DE !== e.stall || fwd_Rs_D !== e.fwd_rs || fwd_Rt_D !== e.fwd_rt ||
                md_busy !== e.busy) begin
                failures++;
                $display("FAIL %s: got stall=%0b en_PC=%0b en_FD=%0b flush_DE=%0b fwd_Rs=%0d fwd_Rt=%0d md_busy=%0b want stall=%0b fwd_Rs=%0d fwd_Rt=%0d md_busy=%0b",
                         e.name, stall, en_PC, en_FD, flush_DE, fwd_Rs_D, fwd_Rt_D, md_busy,
                         e.stall, e.fwd_rs, e.fwd_rt, e.busy);
            end
`ifdef HAZARD_STALL_CNT_EN
            if (e.chk_cnt) begin
                checks++;
                if (stall_cnt !== e.cnt) begin
                    failures++;
                    $display("FAIL %s stall_cnt: got %0d want %0d", e.name, stall_cnt, e.cnt);
                end
            end
`endif
        end
    end

    initial begin
        //   name              rst rs trs rt trt ae te am tm aw  ms mt mu  st frs frt bsy
        vec("reset0",           1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
        vec("reset1",           1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
        vec("reset_comb",       1, 8, 0, 0, 3, 8, 1, 0, 0, 0,  0, 0, 0,  1, 0, 0, 0);
        vec("raw_e_stall",      0, 8, 0, 0, 3, 8, 1, 0, 0, 0,  0, 0, 0,  1, 0, 0, 0);
        vec("raw_e_fwd",        0, 8, 0, 0, 3, 8, 0, 0, 0, 0,  0, 0, 0,  0, 1, 0, 0);
        vec("m_over_w",         0, 0, 3, 5, 1, 0, 0, 5, 0, 5,  0, 0, 0,  0, 0, 2, 0);
        vec("r0_no_hazard",     0, 0, 0, 0, 3, 0, 2, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
        vec("tuse3_no_stall",   0, 9, 3, 0, 3, 9, 2, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
        vec("m_stall_w_fwd",    0, 0, 3, 4, 0, 0, 0, 4, 1, 4,  0, 0, 0,  1, 0, 3, 0);
        vec("tnew_eq_tuse",     0, 7, 1, 0, 3, 7, 1, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
        vec("e_over_m",         0, 6, 0, 0, 3, 6, 0, 6, 0, 0,  0, 0, 0,  0, 1, 0, 0);
        vec("both_from_w",      0, 3, 0, 3, 0, 0, 0, 0, 0, 3,  0, 0, 0,  0, 3, 3, 0);
        vec("m_not_ready_w",    0, 2, 2, 0, 3, 0, 0, 2, 1, 2,  0, 0, 0,  0, 3, 0, 0);

        // Divide with a dependent instruction held in D: 11 stall cycles, 10 busy cycles.
        vec("div_start",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1,  1, 0, 0, 0);
        for (int k = 0; k < 10; k++)
            vec("div_busy",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1,  1, 0, 0, 1);
        vec("div_done",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1,  0, 0, 0, 0);

        // Full multiply with no dependent user: 5 busy cycles, never stalls.
        vec("mul_start_nouse",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0,  0, 0, 0, 0);
        for (int k = 0; k < 5; k++)
            vec("mul_busy_nouse", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
        vec("mul_done_nouse",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);

        // Multiply aborted by reset after two busy cycles.
        vec("mul_start",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1,  1, 0, 0, 0);
        vec("mul_busy1",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1,  1, 0, 0, 1);
        vec("mul_busy2",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1,  1, 0, 0, 1);
        vec("mul_reset",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1,  1, 0, 0, 1);
        vec("mul_after_reset",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1,  0, 0, 0, 0);

        // Reset and md_start on the same edge: reset wins.
        vec("rst_vs_start",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0,  0, 0, 0, 0);
        vec("rst_won",          0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1,  0, 0, 0, 0);

        // Reload: divide interrupted by a multiply start gives 5 fresh busy cycles.
        vec("reload_div",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0,  0, 0, 0, 0);
        vec("reload_busy_a",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 1);
        vec("reload_busy_b",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 1);
        vec("reload_mult",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0,  0, 0, 0, 1);
        for (int k = 0; k < 5; k++)
            vec("reload_busy",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 1);
        vec("reload_done",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);

`ifdef HAZARD_STALL_CNT_EN
        vec("cnt_reset",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
        exp_chk_cnt = 1'b1; exp_cnt = 32'd0;
        vec("cnt_zero",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
        exp_chk_cnt = 1'b0;
        for (int k = 0; k < 7; k++)
            vec("cnt_stall",    0, 8, 0, 0, 3, 8, 1, 0, 0, 0,  0, 0, 0,  1, 0, 0, 0);
        exp_chk_cnt = 1'b1; exp_cnt = 32'd7;
        vec("cnt_seven",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
        exp_chk_cnt = 1'b0;
`endif

        // Drain: every pushed expectation must have been consumed by the monitor.
        repeat (3) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have ports clk (input, 1, clock) and reset (input, 1; reset is synchronous and active-high), listed first.
REQ-002 The block SHALL have inputs Rs_D and Rt_D (5 bits each), the D-stage source register numbers.
REQ-003 The block SHALL have inputs Tuse_Rs_D and Tuse_Rt_D (2 bits each), the D-stage use times; value 3 means the operand is not used.
REQ-004 The block SHALL have inputs A3_E, A3_M and A3_W (5 bits each), the destination registers of stages E, M and W.
REQ-005 The block SHALL have inputs Tnew_E and Tnew_M (2 bits each), the cycles until each stage's result is ready; W is always ready.
REQ-006 The block SHALL have input md_start (1 bit), asserted while a mult/div is issuing in E.
REQ-007 The block SHALL have input md_type (1 bit): 0 selects mult, 1 selects div.
REQ-008 The block SHALL have input md_use_D (1 bit), asserted when the D-stage instruction accesses the mult/div unit or HI/LO.
REQ-009 The block SHALL have outputs stall (1), en_PC (1), en_FD (1) and flush_DE (1).
REQ-010 The block SHALL have outputs fwd_Rs_D and fwd_Rt_D (2 bits each): 0 selects RF, 1 selects E, 2 selects M, 3 selects W.
REQ-011 The block SHALL have output md_busy (1 bit), a registered output.

Function
REQ-012 hit_X(r) SHALL be true when r != 0 and A3_X == r, for X in {E, M, W}.
REQ-013 A data stall SHALL occur when, for r in {Rs_D, Rt_D}, either (hit_E(r) and Tnew_E > Tuse_r) or (hit_M(r) and Tnew_M > Tuse_r).
- Tuse = 3 SHALL never cause a stall.
REQ-014 An md stall SHALL occur when md_use_D and (md_busy or md_start).
REQ-015 stall SHALL be the combinational OR of the data stall and the md stall.
REQ-016 en_PC and en_FD SHALL equal ~stall, and flush_DE SHALL equal stall, so a bubble with Tnew 0 and A3 0 enters E.
REQ-017 fwd_r SHALL be selected by the following priority:
- 1 when hit_E(r) and Tnew_E == 0;
- else 2 when hit_M(r) and Tnew_M == 0;
- else 3 when hit_W(r);
- else 0.
REQ-018 fwd_r SHALL be 0 whenever r == 0.
REQ-019 The block SHALL contain a 4-bit md_cnt.
- On md_start it SHALL load 5 (mult) or 10 (div); md_start while md_cnt != 0 SHALL reload.
- Otherwise, when nonzero, it SHALL decrement by 1 each cycle, stopping at 0 with no wrap.
REQ-020 md_busy SHALL equal (md_cnt != 0), giving exactly 5 or 10 busy cycles starting the cycle after md_start.
REQ-021 Stall and forwarding outputs SHALL be combinational with zero latency; only md_cnt, md_busy and the optional counter are state.

Reset
REQ-022 When reset is high at a clk edge, md_cnt SHALL become 0 and md_busy 0, including in the middle of an operation.
REQ-023 When reset and md_start are sampled high on the same edge, reset SHALL win.
REQ-024 During reset, combinational outputs SHALL still follow their inputs; with all inputs zero: stall=0, en_PC=1, en_FD=1, flush_DE=0, fwd=0.

Configuration
REQ-025 When macro HAZARD_STALL_CNT_EN is defined, the block SHALL have output stall_cnt (32 bits), incremented on every clk edge where stall=1 and reset=0.
- stall_cnt SHALL reset to 0 and wrap from 0xFFFFFFFF to 0.
REQ-026 Without HAZARD_STALL_CNT_EN, the stall_cnt port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-027 Rs_D=8, Tuse_Rs_D=0, A3_E=8, Tnew_E=1 -> stall=1, en_PC=0, flush_DE=1; next cycle with Tnew_E=0 -> stall=0, fwd_Rs_D=1.
REQ-028 Rt_D=5, Tuse_Rt_D=1, A3_M=5, Tnew_M=0, A3_W=5 -> stall=0, fwd_Rt_D=2 (M over W).
REQ-029 Rs_D=0, A3_E=0, Tnew_E=2, Tuse_Rs_D=0 -> stall=0, fwd_Rs_D=0.
REQ-030 md_start=1, md_type=1 for one cycle with md_use_D=1 held:
- md_busy=1 for exactly 10 cycles;
- stall=1 for 11 cycles (including the start cycle), then 0.
REQ-031 Start a mult, then assert reset after 2 busy cycles -> md_busy=0 on the following cycle and stall drops when md_use_D is held.
REQ-032 With HAZARD_STALL_CNT_EN defined, 7 stall cycles after reset -> stall_cnt=7; preloaded at 0xFFFFFFFF, one more stall -> 0.
